// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//
// MEM pipeline stage fused with the MEM/WB pipeline register. A load or store
// arriving from EX/MEM runs a multi-cycle req/ack transaction on the data
// memory port. While it is in flight, stall_o freezes everything upstream.
// The writeback bundle for WB is registered here and updates every cycle.
//
// Optional feature, selected by the MEM_TIMEOUT_EN macro:
//   defined   - BUSY aborts after TIMEOUT_CYCLES cycles without an ack. The
//               aborted instruction is written back with regwrite_o=0,
//               memdata_o=32'hDEADBEEF and timeout_o=1.
//   undefined - BUSY waits for ack indefinitely and timeout_o is tied to 0.
//               The TIMEOUT_CYCLES parameter does not exist in this build.
//
// Parameters:
//   TIMEOUT_CYCLES  BUSY cycle limit (MEM_TIMEOUT_EN builds only)
//   ALIGN_CHECK     1: word-misaligned accesses trap (misalign_o)
//                   0: addr[1:0] is forced to 0 and the access proceeds
//
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   memtoreg_i .. RD_i    EX/MEM register outputs (control, ALU result, store data, rd)
//   mem_req_o .. mem_wdata_o, mem_ack_i, mem_rdata_i
//                         data memory handshake; req is held until ack
//   stall_o               combinational stall to PC/IF/ID/EX/MEM
//   memtoreg_o .. RD_o    registered writeback bundle for WB
//   misalign_o, timeout_o one-cycle flags aligned with the WB bundle
module mem_wb_stage #(
`ifdef MEM_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 64,
`endif
  parameter bit          ALIGN_CHECK    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memtoreg_i,
  input  logic        regwrite_i,
  input  logic        memwrite_i,
  input  logic        memread_i,
  input  logic [31:0] result_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  RD_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        stall_o,
  output logic        memtoreg_o,
  output logic        regwrite_o,
  output logic [31:0] memdata_o,
  output logic [31:0] result_o,
  output logic [4:0]  RD_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] rdata_q;
  logic        acc;
  logic        misaligned;
  logic        start;

  // A store wins when both memread_i and memwrite_i are set, because mem_we_o
  // is taken from memwrite_i alone.
  assign acc        = memread_i | memwrite_i;
  assign misaligned = ALIGN_CHECK && (result_i[1:0] != 2'b00);
  assign start      = (state == IDLE) && acc && !misaligned;

  // Stall covers the issue cycle and every BUSY cycle. DONE does not stall,
  // so the upstream register advances right after WB captures the result.
  assign stall_o = start || (state == BUSY);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CntW-1:0] busy_cnt;
  logic            timed_out;
  logic            timeout_q;

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  // Single FSM block that also owns the memory request registers and the
  // MEM/WB bundle. Each cycle starts from a bubble with the one-cycle flags
  // low. Each state then overrides only the fields it actually loads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rdata_q     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      memtoreg_o  <= 1'b0;
      regwrite_o  <= 1'b0;
      memdata_o   <= '0;
      result_o    <= '0;
      RD_o        <= '0;
      misalign_o  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      busy_cnt    <= '0;
      timed_out   <= 1'b0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      memtoreg_o <= 1'b0;
      regwrite_o <= 1'b0;
      memdata_o  <= '0;
      result_o   <= '0;
      RD_o       <= '0;
      misalign_o <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (!acc) begin
            memtoreg_o <= memtoreg_i;
            regwrite_o <= regwrite_i;
            result_o   <= result_i;
            RD_o       <= RD_i;
          end else if (misaligned) begin
            // The trapped access retires here without a writeback.
            memtoreg_o <= memtoreg_i;
            result_o   <= result_i;
            RD_o       <= RD_i;
            misalign_o <= 1'b1;
          end else begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= memwrite_i;
            mem_addr_o  <= {result_i[31:2], 2'b00};
            mem_wdata_o <= data_i;
            state       <= BUSY;
`ifdef MEM_TIMEOUT_EN
            busy_cnt    <= '0;
            timed_out   <= 1'b0;
`endif
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            rdata_q   <= mem_we_o ? 32'h0 : mem_rdata_i;
            mem_req_o <= 1'b0;
            state     <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (busy_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
            mem_req_o <= 1'b0;
            timed_out <= 1'b1;
            state     <= DONE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          // Upstream still holds the same instruction. Capture it once and
          // return to IDLE without issuing it again.
          memtoreg_o <= memtoreg_i;
          regwrite_o <= regwrite_i;
          memdata_o  <= rdata_q;
          result_o   <= result_i;
          RD_o       <= RD_i;
`ifdef MEM_TIMEOUT_EN
          if (timed_out) begin
            memdata_o  <= 32'hDEADBEEF;
            regwrite_o <= 1'b0;
            timeout_q  <= 1'b1;
            timed_out  <= 1'b0;
          end
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
//
// Self-checking bench for mem_wb_stage. The tasks act as the upstream EX/MEM
// register, which holds each instruction while stall_o is high. They also act
// as the data memory, returning an ack a chosen number of cycles after the
// request rises. An expected WB bundle is queued whenever an instruction that
// must produce a writeback or flag is driven. A negedge monitor pops and
// compares each time the DUT shows regwrite_o, misalign_o or timeout_o.
module tb_mem_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        memtoreg_i, regwrite_i, memwrite_i, memread_i;
  logic [31:0] result_i, data_i;
  logic [4:0]  RD_i;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        stall_o, memtoreg_o, regwrite_o;
  logic [31:0] memdata_o, result_o;
  logic [4:0]  RD_o;
  logic        misalign_o, timeout_o;

  always #5 clk_i = ~clk_i;

  mem_wb_stage #(
`ifdef MEM_TIMEOUT_EN
    .TIMEOUT_CYCLES(8),
`endif
    .ALIGN_CHECK(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .memtoreg_i(memtoreg_i), .regwrite_i(regwrite_i),
    .memwrite_i(memwrite_i), .memread_i(memread_i),
    .result_i(result_i), .data_i(data_i), .RD_i(RD_i),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .stall_o(stall_o), .memtoreg_o(memtoreg_o), .regwrite_o(regwrite_o),
    .memdata_o(memdata_o), .result_o(result_o), .RD_o(RD_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  typedef struct {
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] memdata;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        misalign;
    logic        timeout;
    bit          chk_memdata;
    bit          chk_memtoreg;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  wb_exp_t mon_e;
  int n_vec = 0;
  int n_err = 0;

  // Scoreboard monitor: every visible writeback or flag must match the
  // oldest queued expectation. With an empty queue it counts as an extra event.
  always @(negedge clk_i) begin
    if (regwrite_o === 1'b1 || misalign_o === 1'b1 || timeout_o === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("[TB] FAIL wb_unexpected: got rw=%0b mis=%0b to=%0b rd=%0d result=%h memdata=%h, expected no writeback",
                 regwrite_o, misalign_o, timeout_o, RD_o, result_o, memdata_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (regwrite_o !== mon_e.regwrite || misalign_o !== mon_e.misalign ||
            timeout_o !== mon_e.timeout || result_o !== mon_e.result || RD_o !== mon_e.rd ||
            (mon_e.chk_memdata && memdata_o !== mon_e.memdata) ||
            (mon_e.chk_memtoreg && memtoreg_o !== mon_e.memtoreg)) begin
          n_err++;
          $display("[TB] FAIL wb_bundle: got rw=%0b mt=%0b md=%h res=%h rd=%0d mis=%0b to=%0b, expected rw=%0b mt=%0b md=%h res=%h rd=%0d mis=%0b to=%0b",
                   regwrite_o, memtoreg_o, memdata_o, result_o, RD_o, misalign_o, timeout_o,
                   mon_e.regwrite, mon_e.memtoreg, mon_e.memdata, mon_e.result, mon_e.rd,
                   mon_e.misalign, mon_e.timeout);
        end
      end
    end
  end

  task automatic drive_nop();
    memtoreg_i = 1'b0; regwrite_i = 1'b0; memwrite_i = 1'b0; memread_i = 1'b0;
    result_i = '0; data_i = '0; RD_i = '0;
  endtask

  task automatic idle_cycles(input int n);
    drive_nop();
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Present one non-memory instruction for a single cycle. A stall is never
  // expected for it.
  task automatic issue_alu(input logic [31:0] res, input logic [4:0] rd, input logic rw);
    memread_i = 1'b0; memwrite_i = 1'b0; memtoreg_i = 1'b0;
    regwrite_i = rw; result_i = res; RD_i = rd; data_i = '0;
    if (rw) exp_q.push_back(wb_exp_t'{1'b1, 1'b0, 32'h0, res, rd, 1'b0, 1'b0, 1'b1, 1'b1});
    @(negedge clk_i);
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL alu_stall: got %b, expected 0", stall_o);
    end
    @(posedge clk_i); #1;
  endtask

  // Present a load or store and hold it while stall_o is high. The memory
  // acks in the ack_delay-th cycle during which mem_req_o is seen high.
  task automatic issue_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic [4:0] rd, input logic rw,
                           input int ack_delay);
    int stalls;
    int req_cyc;
    bit done;
    logic [31:0] exp_addr;
    stalls = 0; req_cyc = 0; done = 1'b0;
    exp_addr = {addr[31:2], 2'b00};
    memwrite_i = we; memread_i = !we; memtoreg_i = !we; regwrite_i = rw;
    result_i = addr; data_i = wdata; RD_i = rd;
    if (rw) exp_q.push_back(wb_exp_t'{1'b1, !we, (we ? 32'h0 : rdata), addr, rd,
                                      1'b0, 1'b0, 1'b1, 1'b1});
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      mem_rdata_i = $urandom;
      if (mem_req_o === 1'b1) begin
        req_cyc++;
        n_vec++;
        if (mem_we_o !== we || mem_addr_o !== exp_addr || mem_wdata_o !== wdata) begin
          n_err++;
          $display("[TB] FAIL mem_req_fields: got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                   mem_we_o, mem_addr_o, mem_wdata_o, we, exp_addr, wdata);
        end
        if (req_cyc == ack_delay) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = rdata;
        end
      end
      if (stall_o === 1'b1) stalls++;
      else done = 1'b1;
    end
    n_vec++;
    if (!done || stalls != ack_delay + 1) begin
      n_err++;
      $display("[TB] FAIL stall_count: got %0d cycles (ended=%0b), expected %0d",
               stalls, done, ack_delay + 1);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; drive_nop(); mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_vec++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, memtoreg_o, regwrite_o,
         memdata_o, result_o, RD_o, misalign_o, timeout_o} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h stall=%b rw=%b md=%h res=%h rd=%0d, expected all 0",
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, regwrite_o,
               memdata_o, result_o, RD_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_alu();
    issue_alu(32'h1234, 5'd5, 1'b1);
    issue_alu(32'hFFFF_0003, 5'd31, 1'b1);
    issue_alu(32'h0BAD_0001, 5'd2, 1'b0);
    idle_cycles(2);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL alu_pending: got %0d outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_load();
    issue_mem(1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 5'd6, 1'b1, 1);
    idle_cycles(3);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL load_pending: got %0d outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_store();
    issue_mem(1'b1, 32'h80, 32'h55AA_55AA, 32'hFFFF_0000, 5'd0, 1'b0, 4);
    idle_cycles(3);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL store_pending: got %0d outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_misalign();
    memread_i = 1'b1; memwrite_i = 1'b0; memtoreg_i = 1'b1; regwrite_i = 1'b1;
    result_i = 32'h42; RD_i = 5'd7; data_i = '0;
    exp_q.push_back(wb_exp_t'{1'b0, 1'b1, 32'h0, 32'h42, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk_i);
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL misalign_stall: got %b, expected 0", stall_o);
    end
    @(posedge clk_i); #1;
    drive_nop();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_vec++;
      if (mem_req_o !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL misalign_req: got %b, expected 0", mem_req_o);
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL misalign_pending: got %0d outstanding, expected 0", exp_q.size());
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    issue_alu(32'hA, 5'd1, 1'b1);
    issue_alu(32'hB, 5'd2, 1'b1);
    issue_mem(1'b0, 32'h44, 32'h0, 32'h1111_2222, 5'd4, 1'b1, 2);
    issue_alu(32'hD, 5'd5, 1'b1);
    issue_mem(1'b1, 32'h48, 32'h3333_4444, 32'h0, 5'd6, 1'b1, 1);
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      r[1:0] = 2'b00;
      issue_mem(r[16], r, $urandom, $urandom, 5'(i + 10), 1'b1, 1 + (i % 3));
      issue_alu(r ^ 32'h5A5A_5A5A, 5'(i + 20), 1'b1);
    end
    idle_cycles(3);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL b2b_pending: got %0d outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_busy();
    bit seen;
    seen = 1'b0;
    memread_i = 1'b1; memwrite_i = 1'b0; memtoreg_i = 1'b1; regwrite_i = 1'b1;
    result_i = 32'h100; RD_i = 5'd3; data_i = '0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_i);
      if (mem_req_o === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("[TB] FAIL rstbusy_req: got no request, expected mem_req_o=1");
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    drive_nop();
    @(negedge clk_i);
    n_vec++;
    if ({mem_req_o, stall_o, regwrite_o, memdata_o, result_o, RD_o, misalign_o, timeout_o} !== '0) begin
      n_err++;
      $display("[TB] FAIL rstbusy_outputs: got req=%b stall=%b rw=%b md=%h res=%h rd=%0d, expected all 0",
               mem_req_o, stall_o, regwrite_o, memdata_o, result_o, RD_o);
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_vec++;
    if (mem_req_o !== 1'b0 || regwrite_o !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL rstbusy_late_ack: got req=%b rw=%b pending=%0d, expected 0 0 0",
               mem_req_o, regwrite_o, exp_q.size());
    end
    @(posedge clk_i); #1;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int req_cyc;
    bit dropped;
    req_cyc = 0; dropped = 1'b0;
    mem_ack_i = 1'b0;
    memread_i = 1'b1; memwrite_i = 1'b0; memtoreg_i = 1'b1; regwrite_i = 1'b1;
    result_i = 32'h200; RD_i = 5'd9; data_i = '0;
    exp_q.push_back(wb_exp_t'{1'b0, 1'b1, 32'hDEAD_BEEF, 32'h200, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0});
    for (int c = 0; c < 40 && !dropped; c++) begin
      @(negedge clk_i);
      if (mem_req_o === 1'b1) req_cyc++;
      else if (req_cyc > 0) dropped = 1'b1;
    end
    n_vec++;
    if (!dropped || req_cyc != 8) begin
      n_err++;
      $display("[TB] FAIL timeout_req_cycles: got %0d (dropped=%0b), expected 8", req_cyc, dropped);
    end
    @(posedge clk_i); #1;
    idle_cycles(3);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL timeout_pending: got %0d outstanding, expected 0", exp_q.size());
    end
  endtask
`endif

  initial begin
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    rst_i = 1'b1;
    drive_nop();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misalign();
    test_back_to_back();
    test_reset_busy();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM pipeline stage fused with the MEM/WB pipeline register.
- Consumes the EX/MEM register outputs and runs a multi-cycle req/ack data-memory transaction for loads and stores.
- Drives stall_o back to the EX/MEM register's stall_i while a transaction is in flight.
- Registers the writeback bundle for the WB stage.

Parameters:
- TIMEOUT_CYCLES, 64: max BUSY cycles before abort. Used only with MEM_TIMEOUT_EN.
- ALIGN_CHECK, 1: 1 = trap word-misaligned accesses; 0 = force addr[1:0] to 0 and proceed.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
memtoreg_i  in  1  WB selects memory data
regwrite_i  in  1  instruction writes RD
memwrite_i  in  1  store
memread_i  in  1  load
result_i  in  32  ALU result; memory byte address
data_i  in  32  store data
RD_i  in  5  destination register
mem_ack_i  in  1  memory completion, single-cycle pulse
mem_rdata_i  in  32  load data, valid with mem_ack_i
mem_req_o  out  1  registered request, held until ack
mem_we_o  out  1  1 = write
mem_addr_o  out  32  word-aligned address
mem_wdata_o  out  32  store data
stall_o  out  1  combinational; freezes PC/IF/ID/EX/MEM upstream
memtoreg_o  out  1  to WB
regwrite_o  out  1  to WB
memdata_o  out  32  load data to WB
result_o  out  32  ALU result to WB
RD_o  out  5  to WB
misalign_o  out  1  1-cycle flag, aligned with the WB bundle
timeout_o  out  1  1-cycle flag, aligned with the WB bundle

Behaviour:
- Reset: state=IDLE. All outputs 0, counters 0. Reset overrides every other event.
- Reset mid-transaction: mem_req_o=0 after the reset edge. A late mem_ack_i is ignored.
- acc = memread_i | memwrite_i. If both are set, the access is a write (memread_i ignored).
- FSM states: IDLE, BUSY, DONE.
- IDLE, acc=0: no stall. At the edge, MEM/WB captures memtoreg/regwrite/result/RD; memdata_o<=0.
- IDLE, acc=1, aligned (or ALIGN_CHECK=0):
  - stall_o=1 combinationally this cycle.
  - At the edge: mem_req_o<=1, mem_we_o<=memwrite_i, mem_addr_o<={result_i[31:2],2'b00}, mem_wdata_o<=data_i; go to BUSY.
  - MEM/WB is loaded with a bubble: regwrite_o<=0, memtoreg_o<=0.
- IDLE, acc=1, result_i[1:0]!=0, ALIGN_CHECK=1:
  - No request, no stall.
  - At the edge, MEM/WB captures the instruction with regwrite_o<=0 and misalign_o<=1.
- BUSY:
  - stall_o=1. The WB bundle is held as a bubble (regwrite_o=0).
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable.
  - On an edge with mem_ack_i=1: latch mem_rdata_i (loads only), mem_req_o<=0, go to DONE.
- DONE:
  - stall_o=0. The upstream register still presents the same instruction.
  - At the edge, MEM/WB captures it: memdata_o<=latched rdata (loads) or 0 (stores); regwrite/memtoreg/result/RD pass through.
  - Go to IDLE. No new access starts from DONE, so the same instruction never re-issues.
- mem_ack_i is ignored in IDLE and DONE.
- Latency: ack in the cycle after req rises gives 2 stall cycles; WB data appears 3 edges after the instruction enters. Each extra memory wait cycle adds one stall cycle.
- misalign_o and timeout_o are high for exactly one cycle, coincident with the affected WB bundle; otherwise 0.
- The WB bundle updates every cycle; regwrite_o is never asserted twice for one instruction.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit-or-wider BUSY cycle counter, cleared on BUSY entry.
  - When the count reaches TIMEOUT_CYCLES without ack: mem_req_o<=0, go to DONE.
  - In DONE: memdata_o<=32'hDEADBEEF, regwrite_o<=0, timeout_o<=1.
- MEM_TIMEOUT_EN undefined: BUSY waits indefinitely, timeout_o tied 0, no counter logic.

Test Plan:
- ALU op (result_i=0x1234, RD_i=5, regwrite_i=1): next edge result_o=0x1234, RD_o=5, regwrite_o=1; stall_o never high.
- Load addr 0x40, ack 1 cycle after req with rdata 0xCAFEF00D: stall_o high 2 cycles; mem_addr_o=0x40; then memdata_o=0xCAFEF00D, regwrite_o=1 for exactly one cycle.
- Store addr 0x80 data 0x55AA55AA, ack after 4 wait cycles: mem_we_o=1, wdata stable throughout; stall_o high 5 cycles; regwrite_o stays 0.
- Load at result_i=0x42, ALIGN_CHECK=1: mem_req_o stays 0; misalign_o=1 one cycle; regwrite_o=0.
- rst_i asserted while in BUSY, ack arriving after reset: mem_req_o=0 after the reset edge; all outputs 0; late ack produces no writeback.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack: req drops after 8 BUSY cycles; timeout_o=1, memdata_o=0xDEADBEEF, regwrite_o=0.
